// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_if
// Description : Valid/ready data-memory bus between the MEM-stage LSU and the
//               data memory. The request channel carries one word-aligned
//               access with byte strobes; the response channel returns read
//               data or a write acknowledge.
//   master (LSU)   : drives dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb,
//                    dmem_wdata; samples dmem_req_ready, dmem_rsp_valid,
//                    dmem_rdata
//   slave (memory) : the mirror image of master
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic [XLEN-1:0] dmem_addr;
    logic            dmem_we;
    logic [3:0]      dmem_wstrb;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_rsp_valid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req_valid,
        output dmem_addr,
        output dmem_we,
        output dmem_wstrb,
        output dmem_wdata,
        input  dmem_req_ready,
        input  dmem_rsp_valid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req_valid,
        input  dmem_addr,
        input  dmem_we,
        input  dmem_wstrb,
        input  dmem_wdata,
        output dmem_req_ready,
        output dmem_rsp_valid,
        output dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage
// Description : MEM-stage load/store unit for the RVX10 five-stage pipeline.
//               Runs one load or store over a variable-latency valid/ready
//               data-memory bus, holds the pipeline with stallM while the
//               access is outstanding, and returns the aligned, sign- or
//               zero-extended load result in ReadDataM.
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   MemReadM       : load in MEM (wins if MemWriteM is also high)
//   MemWriteM      : store in MEM
//   funct3M        : access size / signedness
//   ALUResultM     : effective byte address
//   WriteDataM     : store data (rs2)
//   stallM         : hold IF..MEM/WB pipeline registers
//   ReadDataM      : registered extended load result
//   misaligned_exc : combinational misalignment flag for the MEM access
//   dmem           : data-memory bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [2:0]       funct3M,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  WriteDataM,
    output logic             stallM,
    output logic [XLEN-1:0]  ReadDataM,
    output logic             misaligned_exc,
    lsu_mem_stage_if.master  dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT           r_state;
    logic            r_reqValid;
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [3:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic [1:0]      r_byteOff;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_readData;

    logic            w_isByte;
    logic            w_isHalf;
    logic            w_isMem;
    logic            w_misaligned;
    logic            w_access;
    logic            w_we;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_lb;
    logic [15:0]     w_lh;
    logic [XLEN-1:0] w_loadData;

    // Size decode: funct3[1:0] 00 byte, 01 half, anything else is a word
    // (this folds the reserved 011/110/111 encodings into word accesses).
    always_comb begin
        w_isByte     = (funct3M[1:0] == 2'b00);
        w_isHalf     = (funct3M[1:0] == 2'b01);
        w_isMem      = MemReadM | MemWriteM;
        w_misaligned = w_isMem &
                       ((w_isHalf & ALUResultM[0]) |
                        (~w_isByte & ~w_isHalf & (ALUResultM[1:0] != 2'b00)));
        w_access     = w_isMem & ~w_misaligned;
        // A simultaneous read and write request is serviced as a load.
        w_we         = MemWriteM & ~MemReadM;
    end

    // Store lane placement: the data is replicated across all lanes so the
    // strobes alone select which bytes the memory updates.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = WriteDataM;
        if (w_isByte) begin
            w_wdata = {4{WriteDataM[7:0]}};
            w_wstrb = 4'b0001 << ALUResultM[1:0];
        end else if (w_isHalf) begin
            w_wdata = {2{WriteDataM[15:0]}};
            w_wstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
        end else begin
            w_wstrb = 4'b1111;
        end
        if (!w_we) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load extraction uses the captured offset/funct3, since the MEM inputs
    // are only guaranteed stable because the pipeline is stalled.
    always_comb begin
        w_lb = dmem.dmem_rdata[{r_byteOff, 3'b000} +: 8];
        w_lh = r_byteOff[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_lb[7]}}, w_lb};
            3'b001:  w_loadData = {{16{w_lh[15]}}, w_lh};
            3'b100:  w_loadData = {24'd0, w_lb};
            3'b101:  w_loadData = {16'd0, w_lh};
            default: w_loadData = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_reqValid <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wstrb    <= 4'b0000;
            r_wdata    <= '0;
            r_byteOff  <= 2'b00;
            r_funct3   <= 3'b000;
            r_readData <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_addr     <= {ALUResultM[XLEN-1:2], 2'b00};
                        r_we       <= w_we;
                        r_wstrb    <= w_wstrb;
                        r_wdata    <= w_wdata;
                        r_byteOff  <= ALUResultM[1:0];
                        r_funct3   <= funct3M;
                        r_reqValid <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (dmem.dmem_req_ready) begin
                        r_reqValid <= 1'b0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_rsp_valid) begin
                        if (!r_we) begin
                            r_readData <= w_loadData;
                        end
                        r_state <= DONE;
                    end
                end
                // One unstalled cycle lets the pipeline retire the instruction;
                // going straight back to IDLE without sampling w_access keeps
                // the still-visible old request from being issued twice.
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stallM         = ((r_state == IDLE) & w_access) | (r_state == REQ) | (r_state == WAIT);
        misaligned_exc = w_misaligned;
        ReadDataM      = r_readData;
    end

    assign dmem.dmem_req_valid = r_reqValid;
    assign dmem.dmem_addr      = r_addr;
    assign dmem.dmem_we        = r_we;
    assign dmem.dmem_wstrb     = r_wstrb;
    assign dmem.dmem_wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_stage
// Description : Self-checking bench for lsu_mem_stage. A table of load/store
//               vectors is replayed back to back against a bench-side memory
//               responder; expected results are queued when each access is
//               driven and popped when the access completes. Hand-written
//               sequences cover reset during REQ and WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memWord;
        int          readyLow;
        int          rspLow;
        bit          noise;
        logic [31:0] expRead;
        logic [31:0] expAddr;
        logic        expWe;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
        int          expStall;
        bit          expMis;
    } vec_t;

    localparam int c_NVEC = 18;

    logic        clk;
    logic        rst_n;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        stallM;
    logic [31:0] ReadDataM;
    logic        misaligned_exc;

    int checks = 0;
    int errors = 0;

    vec_t vecs [c_NVEC];
    vec_t expQ [$];

    lsu_mem_stage_if #(.XLEN(32)) bus ();

    lsu_mem_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemReadM       (MemReadM),
        .MemWriteM      (MemWriteM),
        .funct3M        (funct3M),
        .ALUResultM     (ALUResultM),
        .WriteDataM     (WriteDataM),
        .stallM         (stallM),
        .ReadDataM      (ReadDataM),
        .misaligned_exc (misaligned_exc),
        .dmem           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        funct3M    = 3'b000;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
    endtask

    // Drives one vector and plays the memory side cycle by cycle. Inputs are
    // changed 1 ns after a rising edge; outputs are sampled on falling edges.
    task automatic runAccess(input vec_t v, input int idx);
        vec_t  e;
        int    phase;
        int    stalls;
        int    rdyCnt;
        int    rspCnt;
        bit    fin;
        string tag;
        tag        = $sformatf("v%0d", idx);
        MemReadM   = v.rd;
        MemWriteM  = v.wr;
        funct3M    = v.f3;
        ALUResultM = v.addr;
        WriteDataM = v.wdata;
        bus.dmem_rdata = v.memWord;
        if (v.expMis) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk({tag, " misaligned_exc"}, {31'd0, misaligned_exc}, 32'd1);
                chk({tag, " stallM"}, {31'd0, stallM}, 32'd0);
                chk({tag, " req_valid"}, {31'd0, bus.dmem_req_valid}, 32'd0);
                chk({tag, " ReadDataM"}, ReadDataM, v.expRead);
            end
        end else begin
            expQ.push_back(v);
            phase  = 0;
            stalls = 0;
            rdyCnt = 0;
            rspCnt = 0;
            fin    = 1'b0;
            for (int c = 0; c < 60 && !fin; c++) begin
                @(negedge clk);
                if (stallM) stalls++;
                if (c == 0) chk({tag, " misaligned_exc"}, {31'd0, misaligned_exc}, 32'd0);
                if (phase == 0 && bus.dmem_req_valid) phase = 1;
                bus.dmem_req_ready = 1'b0;
                bus.dmem_rsp_valid = v.noise;
                case (phase)
                    1: begin
                        chk({tag, " dmem_addr"}, bus.dmem_addr, v.expAddr);
                        chk({tag, " dmem_we"}, {31'd0, bus.dmem_we}, {31'd0, v.expWe});
                        chk({tag, " dmem_wstrb"}, {28'd0, bus.dmem_wstrb}, {28'd0, v.expStrb});
                        if (v.expWe) chk({tag, " dmem_wdata"}, bus.dmem_wdata, v.expWdata);
                        if (rdyCnt >= v.readyLow) begin
                            bus.dmem_req_ready = 1'b1;
                            phase = 2;
                        end
                        rdyCnt++;
                    end
                    2: begin
                        chk({tag, " single request"}, {31'd0, bus.dmem_req_valid}, 32'd0);
                        bus.dmem_req_ready = v.noise;
                        bus.dmem_rsp_valid = (rspCnt >= v.rspLow);
                        if (rspCnt >= v.rspLow) phase = 3;
                        rspCnt++;
                    end
                    3: begin
                        bus.dmem_rsp_valid = 1'b0;
                        e = expQ.pop_front();
                        chk({tag, " stallM in DONE"}, {31'd0, stallM}, 32'd0);
                        chk({tag, " ReadDataM"}, ReadDataM, e.expRead);
                        chk({tag, " stall cycles"}, stalls, e.expStall);
                        fin = 1'b1;
                    end
                    default: ;
                endcase
            end
            bus.dmem_req_ready = 1'b0;
            bus.dmem_rsp_valid = 1'b0;
            if (!fin) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: access did not complete, phase %0d", tag, phase);
                expQ.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          rd    wr    f3      addr        wdata        memWord   rl rs noise expRead     expAddr     we   strb   expWdata   stall mis
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 1'b0, 32'hDEADBEEF, 32'h100, 1'b0, 4'h0, 32'h0,        3, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFF7F, 0, 0, 1'b0, 32'hFFFFFF80, 32'h100, 1'b0, 4'h0, 32'h0,        3, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFF7F, 0, 0, 1'b0, 32'h00000080, 32'h100, 1'b0, 4'h0, 32'h0,        3, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80FFFF7F, 0, 0, 1'b0, 32'hFFFF80FF, 32'h100, 1'b0, 4'h0, 32'h0,        3, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h80FFFF7F, 0, 0, 1'b0, 32'h0000FF7F, 32'h100, 1'b0, 4'h0, 32'h0,        3, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0,        0, 0, 1'b0, 32'h0000FF7F, 32'h204, 1'b1, 4'hC, 32'hABCDABCD, 3, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0,        1, 0, 1'b0, 32'h0000FF7F, 32'h200, 1'b1, 4'h2, 32'hA5A5A5A5, 4, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        3, 1, 1'b0, 32'h0000FF7F, 32'h300, 1'b1, 4'hF, 32'hCAFEF00D, 7, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0000FF7F, 32'h0,   1'b0, 4'h0, 32'h0,        0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0000FF7F, 32'h0,   1'b0, 4'h0, 32'h0,        0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h201, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0000FF7F, 32'h0,   1'b0, 4'h0, 32'h0,        0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 2, 2, 1'b1, 32'h0000007F, 32'h100, 1'b0, 4'h0, 32'h0,        7, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h104, 32'h0,        32'h87654321, 0, 1, 1'b0, 32'h87654321, 32'h104, 1'b0, 4'h0, 32'h0,        4, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h108, 32'hFFFFFFFF, 32'h11223344, 0, 0, 1'b0, 32'h11223344, 32'h108, 1'b0, 4'h0, 32'h0,        3, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h9ABC0000, 0, 0, 1'b0, 32'h00009ABC, 32'h100, 1'b0, 4'h0, 32'h0,        3, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h12345678, 32'h0,        0, 0, 1'b1, 32'h00009ABC, 32'h200, 1'b1, 4'h8, 32'h78787878, 3, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 3'b110, 32'h10C, 32'h0,        32'hF0000001, 1, 1, 1'b0, 32'hF0000001, 32'h10C, 1'b0, 4'h0, 32'h0,        5, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 0, 1'b0, 32'hF0000001, 32'h0,   1'b0, 4'h0, 32'h0,        0, 1'b1};

        rst_n = 1'b0;
        clearInputs();
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_rdata     = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset stallM", {31'd0, stallM}, 32'd0);
        chk("reset req_valid", {31'd0, bus.dmem_req_valid}, 32'd0);
        chk("reset we", {31'd0, bus.dmem_we}, 32'd0);
        chk("reset wstrb", {28'd0, bus.dmem_wstrb}, 32'd0);
        chk("reset addr", bus.dmem_addr, 32'd0);
        chk("reset wdata", bus.dmem_wdata, 32'd0);
        chk("reset ReadDataM", ReadDataM, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle stallM", {31'd0, stallM}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back table replay
        for (int i = 0; i < c_NVEC; i++) begin
            runAccess(vecs[i], i);
        end
        clearInputs();

        // Reset while the request is waiting for ready
        MemReadM   = 1'b1;
        funct3M    = 3'b010;
        ALUResultM = 32'h400;
        @(negedge clk);
        @(negedge clk);
        chk("rstREQ req_valid before", {31'd0, bus.dmem_req_valid}, 32'd1);
        @(negedge clk);
        chk("rstREQ stallM before", {31'd0, stallM}, 32'd1);
        clearInputs();
        #2 rst_n = 1'b0;
        #1;
        chk("rstREQ req_valid", {31'd0, bus.dmem_req_valid}, 32'd0);
        chk("rstREQ stallM", {31'd0, stallM}, 32'd0);
        chk("rstREQ ReadDataM", ReadDataM, 32'd0);
        chk("rstREQ addr", bus.dmem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load a known value, then reset while the next load sits in WAIT
        runAccess('{1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h5A5A5A5A, 0, 0, 1'b0,
                    32'h5A5A5A5A, 32'h500, 1'b0, 4'h0, 32'h0, 3, 1'b0}, 100);
        MemReadM       = 1'b1;
        funct3M        = 3'b010;
        ALUResultM     = 32'h600;
        bus.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        chk("rstWAIT req_valid", {31'd0, bus.dmem_req_valid}, 32'd1);
        bus.dmem_req_ready = 1'b1;
        @(negedge clk);
        bus.dmem_req_ready = 1'b0;
        chk("rstWAIT stallM in WAIT", {31'd0, stallM}, 32'd1);
        @(negedge clk);
        chk("rstWAIT still waiting", {31'd0, stallM}, 32'd1);
        chk("rstWAIT ReadDataM held", ReadDataM, 32'h5A5A5A5A);
        clearInputs();
        #2 rst_n = 1'b0;
        #1;
        chk("rstWAIT stallM", {31'd0, stallM}, 32'd0);
        chk("rstWAIT ReadDataM", ReadDataM, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.dmem_rsp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("late rsp stallM", {31'd0, stallM}, 32'd0);
            chk("late rsp ReadDataM", ReadDataM, 32'd0);
            chk("late rsp req_valid", {31'd0, bus.dmem_req_valid}, 32'd0);
        end
        bus.dmem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;

        // Recovery after reset
        runAccess('{1'b1, 1'b0, 3'b001, 32'h702, 32'h0, 32'h13579BDF, 1, 0, 1'b0,
                    32'h00001357, 32'h700, 1'b0, 4'h0, 32'h0, 4, 1'b0}, 101);
        clearInputs();

        chk("scoreboard drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-stage load/store unit for the RVX10 five-stage pipeline. It takes the MEM-stage load/store request, runs it over a variable-latency valid/ready data-memory bus, and returns aligned, sign- or zero-extended load data. While the access is outstanding it drives `stallM` back to the pipeline control. The load-use hazard logic stalls the pipeline on behalf of a load; this block stalls the pipeline until that load or store has actually been serviced.

## Interface
- `XLEN`, 32, data and address width (only 32 supported)
- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `MemReadM` in 1, load in MEM stage
- `MemWriteM` in 1, store in MEM stage
- `funct3M` in 3, access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- `ALUResultM` in XLEN, effective byte address
- `WriteDataM` in XLEN, store data (rs2)
- `stallM` out 1, hold all pipeline registers IF..MEM/WB
- `ReadDataM` out XLEN, registered extended load result
- `misaligned_exc` out 1, current MEM access is misaligned (combinational)
- `dmem_req_valid` out 1, bus request valid
- `dmem_req_ready` in 1, memory accepts request
- `dmem_addr` out XLEN, word address: `{ALUResultM[31:2], 2'b00}`
- `dmem_we` out 1, 1 = write
- `dmem_wstrb` out 4, byte enables
- `dmem_wdata` out XLEN, lane-replicated store data
- `dmem_rsp_valid` in 1, read data or write ack valid
- `dmem_rdata` in XLEN, read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- Access definition: `access = (MemReadM | MemWriteM) & ~misaligned_exc`.
  - If `MemReadM` and `MemWriteM` are both high, the access is treated as a load.
  - `funct3M` 011, 110 and 111 are treated as word size, zero-extended.
- Misaligned condition: half-word access with `addr[0]=1`, or word access with `addr[1:0]!=0`.
  - No bus request is made and `stallM=0`.
  - `ReadDataM` is unchanged.
- IDLE:
  - On `access`, capture `addr`, `funct3`, `we`, `wstrb` and `wdata`, then go to REQ. `stallM=1` in that same cycle.
  - Otherwise remain in IDLE.
- REQ:
  - `dmem_req_valid=1`, with address, data and strobe held stable from the captured registers.
  - On `dmem_req_ready`, go to WAIT.
- WAIT:
  - Wait for `dmem_rsp_valid`.
  - For a load, latch the extended `dmem_rdata` into `ReadDataM`.
  - Then go to DONE.
- DONE:
  - `stallM=0` for exactly one cycle so the pipeline advances the instruction; then go to IDLE.
  - The IDLE→REQ transition is suppressed in this cycle even though the MEM inputs still show the old instruction.
- `stallM` equation: `(IDLE & access) | REQ | WAIT`.
- Store strobe and data:
  - SB: `wstrb = 1 << addr[1:0]`, data byte replicated ×4.
  - SH: `wstrb = 0011` if `addr[1]=0`, else `1100`; data half-word replicated ×2.
  - SW: `wstrb = 1111`.
  - Loads drive `wstrb = 0000`.
- Load extraction:
  - Select the byte or half-word lane using the captured `addr[1:0]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- `dmem_rsp_valid` outside WAIT is ignored.
- `dmem_req_ready` outside REQ is ignored.

## Timing
- Reset (async assert, sync release):
  - State = IDLE.
  - `dmem_req_valid=0`, `dmem_we=0`, `dmem_wstrb=0`, `dmem_addr=0`, `dmem_wdata=0`, `ReadDataM=0`.
  - `stallM` follows its equation, so it is 0 with no access pending.
- Minimum access, with ready and response immediate:
  - Cycle 0: IDLE, `stallM=1`.
  - Cycle 1: REQ accepted.
  - Cycle 2: WAIT with response.
  - Cycle 3: DONE, `stallM=0`.
  - Total: 3 stall cycles; `ReadDataM` is valid from cycle 3.
- Each cycle `dmem_req_ready` is low in REQ adds one stall cycle. Each cycle `dmem_rsp_valid` is low in WAIT adds one stall cycle.
- Back-to-back accesses: the next instruction's IDLE cycle follows DONE, so there are no lost or duplicate requests.
- Reset asserted in REQ or WAIT:
  - The access is abandoned and the FSM is in IDLE immediately.
  - A late response after reset is ignored.
- `ReadDataM` holds its value until the next load completes. Stores never modify it.

## Test plan
- LW to 0x100, memory returns 0xDEADBEEF with ready and response immediate → `stallM` high exactly 3 cycles; `dmem_addr=0x100`, `wstrb=0000`; `ReadDataM=0xDEADBEEF` in DONE.
- LB to 0x103 with word 0x80FF_FF7F → `ReadDataM=0xFFFFFF80`. LBU to the same address → `ReadDataM=0x00000080`. LH to 0x102 → `ReadDataM=0xFFFF80FF`.
- SH to 0x206, `WriteDataM=0x1234ABCD` → `dmem_we=1`, `wstrb=1100`, `wdata=0xABCDABCD`, `dmem_addr=0x204`; `ReadDataM` unchanged.
- LW to 0x101 → `misaligned_exc=1`, `stallM=0`, `dmem_req_valid` never asserts.
- SW with `dmem_req_ready` low 3 cycles, then response after 2 further cycles → `stallM` high 7 cycles; address, data and strobe stable throughout REQ; exactly one accepted request.
- LW stuck in WAIT, `rst_n` pulsed low, then `dmem_rsp_valid` arrives → FSM in IDLE, `stallM=0`, `ReadDataM=0`, response ignored.
